// File: rtl/kernel_nios2_oci_dct_packer_if.sv
// Frame stream between the DCT packer and the downstream trace consumer:
// a 36-bit {cnt, payload} frame with a valid/ready handshake.
interface kernel_nios2_oci_dct_packer_if;
  logic        frame_valid;
  logic        frame_ready;
  logic [35:0] frame_data;

  modport master (
    output frame_valid,
    output frame_data,
    input  frame_ready
  );

  modport slave (
    input  frame_valid,
    input  frame_data,
    output frame_ready
  );
endinterface

// File: rtl/kernel_nios2_oci_dct_packer.sv
// OCI trace DCT packer: packs taken/not-taken codes into a 30-bit buffer and emits
// DCT/address frames through a small FIFO. Optional macro DCT_DROP_COUNT_EN adds drop_count.
module kernel_nios2_oci_dct_packer #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trc_on,
  input  logic        dct_valid,
  input  logic        dct_taken,
  input  logic        indirect_valid,
  input  logic [31:0] indirect_addr,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        overflow,
`ifdef DCT_DROP_COUNT_EN
  output logic [7:0]  drop_count,
`endif
  kernel_nios2_oci_dct_packer_if.master frame
);

  localparam int               FRAME_W = 36;
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW+1)'(FIFO_DEPTH);

  function automatic logic [1:0] entry_code(input logic taken);
    return taken ? 2'b10 : 2'b01;
  endfunction

`ifdef DCT_DROP_COUNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
`endif

  logic [FRAME_W-1:0] mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   occ;
  logic               trc_on_d;

  logic               app;
  logic [29:0]        buf_app;
  logic [3:0]         cnt_app;
  logic               trc_fall;
  logic               trc_rise;
  logic               dct_flush;
  logic               addr_push;
  logic [1:0]         n_need;
  logic               pop;
  logic [FIFO_AW:0]   free_slots;
  logic               fits;
  logic               drop;
  logic [1:0]         push_n;
  logic [FRAME_W-1:0] dct_frame;
  logic [FRAME_W-1:0] addr_frame;
  logic [FRAME_W-1:0] wr0_data;
  logic [FIFO_AW-1:0] wr_ptr_nx1;

  assign frame.frame_valid = (occ != '0);
  assign frame.frame_data  = frame.frame_valid ? mem[rd_ptr] : '0;

  // Event decode: append first, then decide which frames this cycle must push
  always_comb begin
    app        = trc_on & dct_valid;
    buf_app    = app ? {dct_buffer[27:0], entry_code(dct_taken)} : dct_buffer;
    cnt_app    = app ? dct_count + 4'd1 : dct_count;
    trc_fall   = ~trc_on & trc_on_d;
    trc_rise   = trc_on & ~trc_on_d;
    if (trc_on) begin
      dct_flush = ((cnt_app == 4'd15) | indirect_valid) & (cnt_app != 4'd0);
    end else begin
      dct_flush = trc_fall & (dct_count != 4'd0);
    end
    addr_push  = trc_on & indirect_valid;
    n_need     = 2'(dct_flush) + 2'(addr_push);
    pop        = frame.frame_valid & frame.frame_ready;
    // A pop in the same cycle frees a slot for the incoming frames
    free_slots = DEPTH_L - occ + (FIFO_AW+1)'(pop);
    fits       = (FIFO_AW+1)'(n_need) <= free_slots;
    drop       = (n_need != 2'd0) & ~fits;
    push_n     = fits ? n_need : 2'd0;
    dct_frame  = {cnt_app, 2'b00, buf_app};
    addr_frame = {4'h0, indirect_addr};
    // When both frames go out the DCT frame takes the first slot
    wr0_data   = dct_flush ? dct_frame : addr_frame;
    wr_ptr_nx1 = wr_ptr + FIFO_AW'(1);
  end

  // Frame storage: data only, no reset
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) mem[wr_ptr]     <= wr0_data;
    if (push_n == 2'd2) mem[wr_ptr_nx1] <= addr_frame;
  end

  // Control state: packer buffer, FIFO pointers, trace-enable edge, sticky status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dct_buffer <= '0;
      dct_count  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      trc_on_d   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      trc_on_d <= trc_on;
      if (dct_flush) begin
        dct_buffer <= '0;
        dct_count  <= '0;
      end else begin
        dct_buffer <= buf_app;
        dct_count  <= cnt_app;
      end
      wr_ptr   <= wr_ptr + FIFO_AW'(push_n);
      rd_ptr   <= rd_ptr + FIFO_AW'(pop);
      occ      <= occ + (FIFO_AW+1)'(push_n) - (FIFO_AW+1)'(pop);
      overflow <= (overflow & ~trc_rise) | drop;
    end
  end

`ifdef DCT_DROP_COUNT_EN
  logic [7:0] drop_base;
  assign drop_base = trc_rise ? 8'd0 : drop_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= 8'd0;
    end else begin
      drop_count <= drop ? sat_inc8(drop_base) : drop_base;
    end
  end
`endif

endmodule
